// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_rx;
    logic       done_rx;
    logic       active_rx;
    logic       frame_error;

    // master: the receiver producing bytes; slave: line driver / byte consumer
    modport master (input rx, output data_rx, done_rx, active_rx, frame_error);
    modport slave  (output rx, input data_rx, done_rx, active_rx, frame_error);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with line synchronizer, start-glitch rejection and framing-error flag
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.master bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          active_q, active_d;
    logic          rx_m_q, rx_s_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
            rx_m_q   <= 1'b1;
            rx_s_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
            rx_m_q   <= bus.rx;
            rx_s_q   <= rx_m_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit; a high here was a glitch
                if (cnt_q == CNT_HALF) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered from next state so it rises the cycle after the start edge is seen
        active_d = (state_d != S_IDLE);
    end

    assign bus.data_rx     = data_q;
    assign bus.done_rx     = done_q;
    assign bus.frame_error = ferr_q;
    assign bus.active_rx   = active_q;
endmodule
